mubi4_sync_chk: RTL and testbench

- Receives an asynchronous 4-bit multi-bit boolean (mubi4) control from another clock domain or the BIST/fault-injection path.
- Synchronizes the value, then filters it for stability before handing a clean mubi4 to downstream consumers of the prim_mubi_pkg checkers.
- Detects stable invalid encodings, forces a fail-safe output, raises a four-phase alert handshake and counts invalid events.

---
 rtl/mubi4_sync_chk.sv | 176 +++++++++++++++++
 tb/tb_mubi4_sync_chk.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mubi4_sync_chk.sv
// mubi4_sync_chk: synchronizes an asynchronous mubi4 control, filters it for
// stability, resolves it to a clean True/False value and flags invalid codes
// through a pulse, a saturating counter and a four-phase alert handshake.
module mubi4_sync_chk #(
   parameter int unsigned NumStages       = 2,
   parameter int unsigned StabilityCycles = 2,
   parameter logic [3:0]  ResetValue      = 4'h9,
   parameter int unsigned InvalCntWidth   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [3:0]               mubi_i,
   output logic [3:0]               mubi_o,
   output logic                     invalid_o,
   output logic                     alert_req_o,
   input  logic                     alert_ack_i,
   input  logic                     clr_cnt_i,
   output logic [InvalCntWidth-1:0] inval_cnt_o
);

   localparam logic [3:0] MuBi4True  = 4'h6;
   localparam logic [3:0] MuBi4False = 4'h9;

   localparam int unsigned StabW = (StabilityCycles < 2) ? 1 : $clog2(StabilityCycles + 1);
   localparam logic [StabW-1:0] StabMax = StabW'(StabilityCycles);

   // Reject parameter combinations that would break the fail-safe contract.
   if (NumStages < 2 || NumStages > 4) begin : gen_bad_num_stages
      $error("mubi4_sync_chk: NumStages must be in 2..4");
   end
   if (StabilityCycles < 1) begin : gen_bad_stability
      $error("mubi4_sync_chk: StabilityCycles must be >= 1");
   end
   if (ResetValue != MuBi4True && ResetValue != MuBi4False) begin : gen_bad_reset_value
      $error("mubi4_sync_chk: ResetValue must be MuBi4True or MuBi4False");
   end

   typedef enum logic [1:0] {
      AlertIdle,
      AlertReq,
      AlertWaitAckLow
   } alert_state_e;

   logic [NumStages-1:0][3:0] sync_q, sync_d;
   logic [3:0]                sync_out;
   logic [3:0]                cand_q, cand_d;
   logic [StabW-1:0]          stab_cnt_q, stab_cnt_d;
   logic                      stable_evt_q, stable_evt_d;
   logic [3:0]                mubi_q, mubi_d;
   logic                      invalid_q, invalid_d;
   logic [InvalCntWidth-1:0]  cnt_q, cnt_d;
   alert_state_e              state_q, state_d;
   logic                      pending_q, pending_d;
   logic                      cand_valid;
   logic                      inval_evt;

   assign sync_out = sync_q[NumStages-1];

   // Shift the raw input through the synchronizer chain, newest sample in stage 0.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = mubi_i;
      for (int i = 1; i < NumStages; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Track the current candidate value and how long it has been seen unchanged;
   // the stable event fires on the edge where the run length reaches the threshold.
   always_comb begin
      cand_d       = cand_q;
      stab_cnt_d   = stab_cnt_q;
      stable_evt_d = 1'b0;
      if (sync_out != cand_q) begin
         cand_d       = sync_out;
         stab_cnt_d   = StabW'(1);
         stable_evt_d = (StabilityCycles == 1);
      end else if (stab_cnt_q < StabMax) begin
         stab_cnt_d   = stab_cnt_q + 1'b1;
         stable_evt_d = (stab_cnt_q == (StabMax - 1'b1));
      end
   end

   assign cand_valid = (cand_q == MuBi4True) || (cand_q == MuBi4False);
   assign inval_evt  = stable_evt_q && !cand_valid;

   // Resolve the stable candidate to a clean output; anything but True is False.
   always_comb begin
      mubi_d    = mubi_q;
      invalid_d = inval_evt;
      if (stable_evt_q) begin
         mubi_d = (cand_q == MuBi4True) ? MuBi4True : MuBi4False;
      end
   end

   // Saturating invalid-event counter; a clear still lets a same-cycle event count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt_i) begin
         cnt_d = inval_evt ? InvalCntWidth'(1) : '0;
      end else if (inval_evt && (cnt_q != {InvalCntWidth{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Alert handshake: raise request, wait for ack, wait for ack to drop, and
   // replay once if further invalid events arrived during the handshake.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      unique case (state_q)
         AlertIdle: begin
            if (inval_evt) begin
               state_d = AlertReq;
            end
         end
         AlertReq: begin
            if (inval_evt) begin
               pending_d = 1'b1;
            end
            if (alert_ack_i) begin
               state_d = AlertWaitAckLow;
            end
         end
         AlertWaitAckLow: begin
            if (inval_evt) begin
               pending_d = 1'b1;
            end
            if (!alert_ack_i) begin
               if (pending_q || inval_evt) begin
                  state_d   = AlertReq;
                  pending_d = 1'b0;
               end else begin
                  state_d = AlertIdle;
               end
            end
         end
         default: begin
            state_d   = AlertIdle;
            pending_d = 1'b0;
         end
      endcase
   end

   // All state registers share one asynchronous reset so a mid-handshake reset
   // drops the alert and restores the fail-safe value at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q       <= {NumStages{ResetValue}};
         cand_q       <= ResetValue;
         stab_cnt_q   <= StabMax;
         stable_evt_q <= 1'b0;
         mubi_q       <= ResetValue;
         invalid_q    <= 1'b0;
         cnt_q        <= '0;
         state_q      <= AlertIdle;
         pending_q    <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         cand_q       <= cand_d;
         stab_cnt_q   <= stab_cnt_d;
         stable_evt_q <= stable_evt_d;
         mubi_q       <= mubi_d;
         invalid_q    <= invalid_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         pending_q    <= pending_d;
      end
   end

   assign mubi_o      = mubi_q;
   assign invalid_o   = invalid_q;
   assign inval_cnt_o = cnt_q;
   assign alert_req_o = (state_q == AlertReq);

endmodule

// File: tb/tb_mubi4_sync_chk.sv
// Testbench for mubi4_sync_chk: directed scenarios with literal expectations
// plus a randomized phase compared every cycle against a history-based model.
module tb_mubi4_sync_chk;

   localparam int NS = 2;
   localparam int SC = 2;
   localparam int HL = NS + SC + 3;

   logic       clk_i;
   logic       rst_i;
   logic [3:0] mubi_i;
   logic [3:0] mubi_o;
   logic       invalid_o;
   logic       alert_req_o;
   logic       alert_ack_i;
   logic       clr_cnt_i;
   logic [7:0] inval_cnt_o;

   int testsRun;
   int testsFailed;

   mubi4_sync_chk #(
      .NumStages(NS),
      .StabilityCycles(SC),
      .ResetValue(4'h9),
      .InvalCntWidth(8)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .mubi_i(mubi_i),
      .mubi_o(mubi_o),
      .invalid_o(invalid_o),
      .alert_req_o(alert_req_o),
      .alert_ack_i(alert_ack_i),
      .clr_cnt_i(clr_cnt_i),
      .inval_cnt_o(inval_cnt_o)
   );

   // Free-running clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Reference model state: history of sampled inputs (index 0 = newest edge),
   // entries flagged "pre" stand for the endless reset-value run before reset release.
   logic [3:0] hv[$];
   bit         hpre[$];
   logic [3:0] expMubi;
   bit         expInv;
   bit         expReq;
   int         expCnt;
   bit         waitLow;
   bit         owed;

   task automatic modelReset();
      hv.delete();
      hpre.delete();
      for (int i = 0; i < HL; i++) begin
         hv.push_back(4'h9);
         hpre.push_back(1'b1);
      end
      expMubi = 4'h9;
      expInv  = 1'b0;
      expReq  = 1'b0;
      expCnt  = 0;
      waitLow = 1'b0;
      owed    = 1'b0;
   endtask

   task automatic modelStep(input logic [3:0] m, input bit ack, input bit clr);
      logic [3:0] v;
      int  runLen;
      bit  endless;
      bit  evt;
      bit  iv;
      hv.push_front(m);
      hpre.push_front(1'b0);
      void'(hv.pop_back());
      void'(hpre.pop_back());
      // The value whose run just reached the threshold was sampled NS+1 edges ago.
      v       = hv[NS+1];
      runLen  = 0;
      endless = 1'b0;
      for (int i = NS + 1; i < HL; i++) begin
         if (hv[i] != v) break;
         if (hpre[i]) begin
            endless = 1'b1;
            break;
         end
         runLen++;
      end
      evt = !endless && (runLen == SC);
      iv  = evt && (v != 4'h6) && (v != 4'h9);
      expInv = iv;
      if (evt) expMubi = (v == 4'h6) ? 4'h6 : 4'h9;
      if (clr) expCnt = iv ? 1 : 0;
      else if (iv && expCnt < 255) expCnt++;
      if (!expReq && !waitLow) begin
         if (iv) expReq = 1'b1;
      end else if (expReq) begin
         if (iv) owed = 1'b1;
         if (ack) begin
            expReq  = 1'b0;
            waitLow = 1'b1;
         end
      end else begin
         if (iv) owed = 1'b1;
         if (!ack) begin
            waitLow = 1'b0;
            if (owed) begin
               expReq = 1'b1;
               owed   = 1'b0;
            end
         end
      end
   endtask

   // Advance the model on every clock edge, reset asynchronously with the DUT.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) modelReset();
      else modelStep(mubi_i, alert_ack_i, clr_cnt_i);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs against the model once per cycle, away from the active edge.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         checkOutput("model mubi_o", 32'(mubi_o), 32'(expMubi));
         checkOutput("model invalid_o", 32'(invalid_o), 32'(expInv));
         checkOutput("model alert_req_o", 32'(alert_req_o), 32'(expReq));
         checkOutput("model inval_cnt_o", 32'(inval_cnt_o), 32'(expCnt));
      end
   end

   // Drive inputs at a falling edge and hold them for the given number of cycles.
   task automatic applyStimulus(input logic [3:0] m, input logic ack, input logic clr, input int cycles);
      mubi_i      = m;
      alert_ack_i = ack;
      clr_cnt_i   = clr;
      repeat (cycles) @(negedge clk_i);
   endtask

   task automatic doReset();
      rst_i       = 1'b1;
      mubi_i      = 4'h9;
      alert_ack_i = 1'b0;
      clr_cnt_i   = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   int holdLeft;
   logic [3:0] curVal;
   logic curAck;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_i       = 1'b1;
      mubi_i      = 4'h9;
      alert_ack_i = 1'b0;
      clr_cnt_i   = 1'b0;
      @(negedge clk_i);
      doReset();

      // Reset state with a constant False input.
      applyStimulus(4'h9, 1'b0, 1'b0, 8);
      checkOutput("reset mubi_o", 32'(mubi_o), 32'h9);
      checkOutput("reset alert_req_o", 32'(alert_req_o), 32'h0);
      checkOutput("reset inval_cnt_o", 32'(inval_cnt_o), 32'h0);

      // False -> True: output changes after the fifth edge, not before.
      applyStimulus(4'h6, 1'b0, 1'b0, 4);
      checkOutput("latency mubi_o edge4", 32'(mubi_o), 32'h9);
      applyStimulus(4'h6, 1'b0, 1'b0, 1);
      checkOutput("latency mubi_o edge5", 32'(mubi_o), 32'h6);
      checkOutput("latency invalid_o", 32'(invalid_o), 32'h0);

      // One-cycle glitch never reaches the output.
      doReset();
      applyStimulus(4'h6, 1'b0, 1'b0, 1);
      applyStimulus(4'h9, 1'b0, 1'b0, 10);
      checkOutput("glitch mubi_o", 32'(mubi_o), 32'h9);

      // Held invalid code: one pulse, one count, alert until ack.
      doReset();
      applyStimulus(4'h0, 1'b0, 1'b0, 4);
      checkOutput("inval pre invalid_o", 32'(invalid_o), 32'h0);
      applyStimulus(4'h0, 1'b0, 1'b0, 1);
      checkOutput("inval pulse invalid_o", 32'(invalid_o), 32'h1);
      checkOutput("inval mubi_o", 32'(mubi_o), 32'h9);
      checkOutput("inval cnt", 32'(inval_cnt_o), 32'h1);
      checkOutput("inval alert_req_o", 32'(alert_req_o), 32'h1);
      applyStimulus(4'h0, 1'b0, 1'b0, 5);
      checkOutput("inval single pulse", 32'(invalid_o), 32'h0);
      checkOutput("inval req held", 32'(alert_req_o), 32'h1);
      applyStimulus(4'h0, 1'b1, 1'b0, 1);
      checkOutput("inval req after ack", 32'(alert_req_o), 32'h0);
      applyStimulus(4'h0, 1'b0, 1'b0, 9);
      checkOutput("inval req idle", 32'(alert_req_o), 32'h0);
      checkOutput("inval cnt held", 32'(inval_cnt_o), 32'h1);

      // Two invalid episodes while ack is withheld: one replayed request.
      doReset();
      applyStimulus(4'h0, 1'b0, 1'b0, 5);
      applyStimulus(4'hF, 1'b0, 1'b0, 5);
      checkOutput("two ep cnt", 32'(inval_cnt_o), 32'h2);
      checkOutput("two ep req", 32'(alert_req_o), 32'h1);
      applyStimulus(4'hF, 1'b1, 1'b0, 1);
      checkOutput("two ep first ack", 32'(alert_req_o), 32'h0);
      applyStimulus(4'hF, 1'b0, 1'b0, 1);
      checkOutput("two ep replay", 32'(alert_req_o), 32'h1);
      applyStimulus(4'hF, 1'b1, 1'b0, 1);
      applyStimulus(4'hF, 1'b0, 1'b0, 4);
      checkOutput("two ep done", 32'(alert_req_o), 32'h0);

      // Saturation: alternate two invalid codes to produce many events.
      doReset();
      for (int i = 0; i < 140; i++) begin
         applyStimulus(4'h0, 1'b0, 1'b0, 2);
         applyStimulus(4'hF, 1'b0, 1'b0, 2);
      end
      applyStimulus(4'hF, 1'b0, 1'b0, 8);
      checkOutput("sat cnt", 32'(inval_cnt_o), 32'hFF);
      applyStimulus(4'h0, 1'b0, 1'b0, 8);
      checkOutput("sat cnt stays", 32'(inval_cnt_o), 32'hFF);

      // Clear together with an invalid event leaves a count of one.
      applyStimulus(4'h5, 1'b0, 1'b0, 4);
      applyStimulus(4'h5, 1'b0, 1'b1, 1);
      clr_cnt_i = 1'b0;
      checkOutput("clr with event", 32'(inval_cnt_o), 32'h1);

      // Asynchronous reset in the middle of a handshake with True on the output.
      doReset();
      applyStimulus(4'h0, 1'b0, 1'b0, 5);
      applyStimulus(4'h6, 1'b0, 1'b0, 5);
      checkOutput("midrst pre mubi_o", 32'(mubi_o), 32'h6);
      checkOutput("midrst pre req", 32'(alert_req_o), 32'h1);
      #2 rst_i = 1'b1;
      #1;
      checkOutput("midrst req", 32'(alert_req_o), 32'h0);
      checkOutput("midrst mubi_o", 32'(mubi_o), 32'h9);
      checkOutput("midrst cnt", 32'(inval_cnt_o), 32'h0);
      mubi_i = 4'h9;
      @(negedge clk_i);
      rst_i = 1'b0;

      // Randomized traffic, checked each cycle by the model.
      holdLeft = 0;
      curVal   = 4'h9;
      curAck   = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (holdLeft == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: curVal = 4'h6;
               4, 5, 6, 7: curVal = 4'h9;
               default:    curVal = 4'($urandom_range(0, 15));
            endcase
            holdLeft = $urandom_range(1, 6);
         end
         holdLeft--;
         if ($urandom_range(0, 3) == 0) curAck = ~curAck;
         if (cyc == 2000) begin
            doReset();
         end
         applyStimulus(curVal, curAck, ($urandom_range(0, 49) == 0), 1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
